// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// slave = arbiter view, master = requesters plus RAM model view.
interface ram_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              r0_req;
   logic              r1_req;
   logic              r0_we;
   logic              r1_we;
   logic              r0_lock;
   logic              r1_lock;
   logic [ADDR_W-1:0] r0_addr;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic [DATA_W-1:0] r1_wdata;
   logic              r0_gnt;
   logic              r1_gnt;
   logic              r0_rvalid;
   logic              r1_rvalid;
   logic [DATA_W-1:0] r0_rdata;
   logic [DATA_W-1:0] r1_rdata;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock,
      input  r0_addr, r1_addr, r0_wdata, r1_wdata, ram_rdata,
      output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock,
      output r0_addr, r1_addr, r0_wdata, r1_wdata, ram_rdata,
      input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single-port data RAM with lock and lock timeout.
// RAM_ARB_RR_EN selects round-robin IDLE arbitration; default is fixed priority (requester 0 first).
module ram_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_LOCK = 8
) (
   input  logic          clk,
   input  logic          sync_rst,
   input  logic          clk_en,
   ram_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(MAX_LOCK) + 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              yield_q, yield_d;
   logic              yield_id_q, yield_id_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;

   logic              active_s;
   logic              cand0_s, cand1_s;
   logic              win0_s, win1_s;
   logic              gnt0_s, gnt1_s;
   logic              ram_en_s, ram_we_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic [DATA_W-1:0] ram_wdata_s;

   // Grant decision: IDLE arbitration with yield exclusion, or owner-only while locked
   always_comb begin
      active_s = clk_en & ~sync_rst;
      cand0_s  = bus.r0_req & ~(yield_q & ~yield_id_q);
      cand1_s  = bus.r1_req & ~(yield_q & yield_id_q);
`ifdef RAM_ARB_RR_EN
      win0_s   = cand0_s & (~cand1_s | last_q);
`else
      win0_s   = cand0_s;
`endif
      win1_s   = cand1_s & ~win0_s;
      gnt0_s   = 1'b0;
      gnt1_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            gnt0_s = active_s & win0_s;
            gnt1_s = active_s & win1_s;
         end
         ST_LOCK0: gnt0_s = active_s & bus.r0_req;
         ST_LOCK1: gnt1_s = active_s & bus.r1_req;
         default: begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
         end
      endcase
   end

   // RAM command mux; idle cycles drive an all-zero command
   always_comb begin
      ram_en_s    = gnt0_s | gnt1_s;
      ram_we_s    = 1'b0;
      ram_addr_s  = '0;
      ram_wdata_s = '0;
      if (gnt0_s) begin
         ram_we_s    = bus.r0_we;
         ram_addr_s  = bus.r0_addr;
         ram_wdata_s = bus.r0_wdata;
      end else if (gnt1_s) begin
         ram_we_s    = bus.r1_we;
         ram_addr_s  = bus.r1_addr;
         ram_wdata_s = bus.r1_wdata;
      end else begin
         ram_we_s    = 1'b0;
      end
   end

   // Next-state logic; with clk_en low every register holds
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      yield_d    = yield_q;
      yield_id_d = yield_id_q;
      rvalid0_d  = rvalid0_q;
      rvalid1_d  = rvalid1_q;
      if (clk_en) begin
         rvalid0_d = gnt0_s & ~bus.r0_we;
         rvalid1_d = gnt1_s & ~bus.r1_we;
         if (gnt0_s) begin
            last_d = 1'b0;
         end else if (gnt1_s) begin
            last_d = 1'b1;
         end else begin
            last_d = last_q;
         end
         case (state_q)
            ST_IDLE: begin
               yield_d = 1'b0;
               if (gnt0_s & bus.r0_lock) begin
                  state_d = ST_LOCK0;
                  cnt_d   = CNT_ONE;
               end else if (gnt1_s & bus.r1_lock) begin
                  state_d = ST_LOCK1;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOCK0: begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d    = ST_IDLE;
                  cnt_d      = CNT_ZERO;
                  yield_d    = 1'b1;
                  yield_id_d = 1'b0;
               end else if (!bus.r0_lock) begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end else begin
                  state_d = ST_LOCK0;
               end
            end
            ST_LOCK1: begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d    = ST_IDLE;
                  cnt_d      = CNT_ZERO;
                  yield_d    = 1'b1;
                  yield_id_d = 1'b1;
               end else if (!bus.r1_lock) begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end else begin
                  state_d = ST_LOCK1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State registers; reset wins over clk_en
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;
         cnt_q      <= CNT_ZERO;
         yield_q    <= 1'b0;
         yield_id_q <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         yield_q    <= yield_d;
         yield_id_q <= yield_id_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
      end
   end

   assign bus.r0_gnt    = gnt0_s;
   assign bus.r1_gnt    = gnt1_s;
   assign bus.r0_rvalid = rvalid0_q;
   assign bus.r1_rvalid = rvalid1_q;
   assign bus.r0_rdata  = bus.ram_rdata;
   assign bus.r1_rdata  = bus.ram_rdata;
   assign bus.ram_en    = ram_en_s;
   assign bus.ram_we    = ram_we_s;
   assign bus.ram_addr  = ram_addr_s;
   assign bus.ram_wdata = ram_wdata_s;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter (MAX_LOCK=4); expectations follow RAM_ARB_RR_EN when defined.
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic sync_rst;
   logic clk_en;
   logic ram_init;
   logic mon_on = 1'b0;
   logic edge_en_q = 1'b0;

   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   ram_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_LOCK(4)) dut (
      .clk      (clk),
      .sync_rst (sync_rst),
      .clk_en   (clk_en),
      .bus      (bus)
   );

   typedef struct packed {
      logic        g0;
      logic        g1;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } cyc_t;

   typedef struct packed {
      logic        id;
      logic [15:0] data;
   } rd_t;

   cyc_t        cq[$];
   rd_t         rq[$];
   int          checks = 0;
   int          failures = 0;
   logic [15:0] ram     [0:255];
   logic [15:0] exp_mem [0:255];
   cyc_t        mon_e, mon_a;
   rd_t         mon_r;
   logic        act_id;
   logic [15:0] act_data;

   // Synchronous-read RAM sharing clk_en with the arbiter
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 16'hC300 | 16'(i);
         ram[16] <= 16'hBEEF;
         bus.ram_rdata <= 16'h0000;
      end else if (clk_en && bus.ram_en) begin
         if (bus.ram_we) ram[bus.ram_addr[7:0]] <= bus.ram_wdata;
         else bus.ram_rdata <= ram[bus.ram_addr[7:0]];
      end
   end

   always @(posedge clk) edge_en_q <= clk_en;

   // Monitor: one command record per cycle, one read record per fresh rvalid
   always @(negedge clk) begin
      if (mon_on) begin
         mon_a = {bus.r0_gnt, bus.r1_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata};
         checks++;
         if (cq.size() == 0) begin
            failures++;
            $display("FAIL cycle: no expectation queued, got %h", mon_a);
         end else begin
            mon_e = cq.pop_front();
            if (mon_a !== mon_e || bus.ram_en !== (mon_e.g0 | mon_e.g1)) begin
               failures++;
               $display("FAIL cycle: got gnt0=%b gnt1=%b en=%b we=%b addr=%h wdata=%h, expected gnt0=%b gnt1=%b we=%b addr=%h wdata=%h",
                        mon_a.g0, mon_a.g1, bus.ram_en, mon_a.we, mon_a.addr, mon_a.wdata,
                        mon_e.g0, mon_e.g1, mon_e.we, mon_e.addr, mon_e.wdata);
            end
         end
         if (edge_en_q && (bus.r0_rvalid || bus.r1_rvalid)) begin
            checks++;
            if (bus.r0_rvalid && bus.r1_rvalid) begin
               failures++;
               $display("FAIL rvalid_both: got both rvalid high, expected at most one");
            end else if (rq.size() == 0) begin
               failures++;
               $display("FAIL rvalid_unexpected: got rvalid0=%b rvalid1=%b, expected none", bus.r0_rvalid, bus.r1_rvalid);
            end else begin
               mon_r    = rq.pop_front();
               act_id   = bus.r1_rvalid;
               act_data = act_id ? bus.r1_rdata : bus.r0_rdata;
               if (act_id !== mon_r.id || act_data !== mon_r.data) begin
                  failures++;
                  $display("FAIL rdata: got id=%0d data=%h, expected id=%0d data=%h", act_id, act_data, mon_r.id, mon_r.data);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic req0(input logic r, input logic we, input logic lk, input logic [15:0] a, input logic [15:0] d);
      bus.r0_req = r; bus.r0_we = we; bus.r0_lock = lk; bus.r0_addr = a; bus.r0_wdata = d;
   endtask

   task automatic req1(input logic r, input logic we, input logic lk, input logic [15:0] a, input logic [15:0] d);
      bus.r1_req = r; bus.r1_we = we; bus.r1_lock = lk; bus.r1_addr = a; bus.r1_wdata = d;
   endtask

   // Queue the expected command for this cycle (eid 0/1 = that requester granted, 2 = none)
   task automatic step(input int eid);
      cyc_t c;
      c = '0;
      if (eid == 0) begin
         c.g0 = 1'b1; c.we = bus.r0_we; c.addr = bus.r0_addr; c.wdata = bus.r0_wdata;
         if (bus.r0_we) exp_mem[bus.r0_addr[7:0]] = bus.r0_wdata;
         else rq.push_back({1'b0, exp_mem[bus.r0_addr[7:0]]});
      end else if (eid == 1) begin
         c.g1 = 1'b1; c.we = bus.r1_we; c.addr = bus.r1_addr; c.wdata = bus.r1_wdata;
         if (bus.r1_we) exp_mem[bus.r1_addr[7:0]] = bus.r1_wdata;
         else rq.push_back({1'b1, exp_mem[bus.r1_addr[7:0]]});
      end
      cq.push_back(c);
      @(posedge clk);
      #1;
   endtask

   initial begin
      sync_rst = 1'b1; clk_en = 1'b1; ram_init = 1'b1;
      req0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      req1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      for (int i = 0; i < 256; i++) exp_mem[i] = 16'hC300 | 16'(i);
      exp_mem[16] = 16'hBEEF;
      @(posedge clk);
      #1;
      ram_init = 1'b0;
      req0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
      #1;
      chk("rst_gnt0",    16'(bus.r0_gnt),    16'h0000);
      chk("rst_gnt1",    16'(bus.r1_gnt),    16'h0000);
      chk("rst_ram_en",  16'(bus.ram_en),    16'h0000);
      chk("rst_addr",    bus.ram_addr,       16'h0000);
      chk("rst_rvalid0", 16'(bus.r0_rvalid), 16'h0000);
      chk("rst_rvalid1", 16'(bus.r1_rvalid), 16'h0000);
      mon_on = 1'b1;
      step(2);

      // Single read of 0x0010 (0xBEEF), then r1 write so last=1
      sync_rst = 1'b0;
      step(0);
      req0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      req1(1'b1, 1'b1, 1'b0, 16'h0040, 16'h4444);
      step(1);

      // Contention: continuous reads from both
      req0(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
      req1(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
      for (int k = 0; k < 6; k++) begin
`ifdef RAM_ARB_RR_EN
         step(k % 2);
`else
         step(0);
`endif
      end

      // Locked push: write lock=1, write lock=0, then r1 gets in
      req0(1'b1, 1'b1, 1'b1, 16'h0050, 16'h1111);
      req1(1'b1, 1'b0, 1'b0, 16'h0051, 16'h0000);
      step(0);
      req0(1'b1, 1'b1, 1'b0, 16'h0051, 16'h2222);
      step(0);
      req0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1);

      // Lock timeout with MAX_LOCK=4: four r0 grants, then r1
      req0(1'b1, 1'b0, 1'b1, 16'h0060, 16'h0000);
      req1(1'b1, 1'b0, 1'b0, 16'h0061, 16'h0000);
      step(0); step(0); step(0); step(0);
      step(1);
      req0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      req1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(2);

      // clk_en stall right after an r1 read grant
      req1(1'b1, 1'b0, 1'b0, 16'h0070, 16'h0000);
      step(1);
      clk_en = 1'b0;
      req0(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
      req1(1'b1, 1'b0, 1'b0, 16'h0071, 16'h0000);
      chk("stall_rvalid1_s1", 16'(bus.r1_rvalid), 16'h0001);
      step(2);
      chk("stall_rvalid1_s2", 16'(bus.r1_rvalid), 16'h0001);
      step(2);
      chk("stall_rvalid1_s3", 16'(bus.r1_rvalid), 16'h0001);
      step(2);
      clk_en = 1'b1;
      req0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      req1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("stall_rvalid1_hold", 16'(bus.r1_rvalid), 16'h0001);
      chk("stall_rdata1_hold",  bus.r1_rdata,       16'hC370);
      step(2);
      chk("stall_rvalid1_drop", 16'(bus.r1_rvalid), 16'h0000);

      // Reset while in LOCK1 (clk_en low), then r0 wins in IDLE
      req1(1'b1, 1'b0, 1'b1, 16'h0080, 16'h0000);
      step(1);
      sync_rst = 1'b1;
      clk_en   = 1'b0;
      req0(1'b1, 1'b0, 1'b0, 16'h0081, 16'h0000);
      req1(1'b1, 1'b0, 1'b1, 16'h0082, 16'h0000);
      step(2);
      sync_rst = 1'b0;
      clk_en   = 1'b1;
      chk("post_rst_rvalid1", 16'(bus.r1_rvalid), 16'h0000);
      step(0);
      req0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      req1(1'b1, 1'b0, 1'b0, 16'h0082, 16'h0000);
      step(1);
      req1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(2);
      step(2);
      mon_on = 1'b0;

      checks++;
      if (cq.size() != 0 || rq.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d command and %0d read expectations left, expected 0 and 0", cq.size(), rq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
